// File: rtl/clk_sel_ctrl.sv
// Clock-select controller for a glitch-free BUFGMUX: activity monitor, debounced select, auto failover.
// Define CLK_SEL_STATUS_EN to add the switch_cnt / fail_p status outputs.
module clk_sel_ctrl #(
    parameter int WIN_LEN   = 1024,
    parameter int MIN_TOG   = 4,
    parameter int HOLD_CYC  = 64,
    parameter bit PRESELECT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk0_tog,
    input  logic       clk1_tog,
    input  logic       req_sel,
    input  logic       auto_en,
    output logic       sel,
    output logic [1:0] alive,
    output logic       busy,
`ifdef CLK_SEL_STATUS_EN
    output logic [7:0] switch_cnt,
    output logic [0:0] fail_p,
`endif
    output logic [1:0] o_dbg_state
);

    localparam int WW = $clog2(WIN_LEN);
    localparam int CW = $clog2(MIN_TOG + 1);
    localparam int HW = $clog2(HOLD_CYC);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
    localparam logic [CW-1:0] TOG_SAT   = CW'(MIN_TOG);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_ARM    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    // [0],[1] synchronize the toggle; [2] is the edge-detect history
    logic [2:0]    r_sync0;
    logic [2:0]    r_sync1;
    logic [WW-1:0] r_win;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;
    logic [1:0]    r_alive;
    state_t        r_state;
    logic [HW-1:0] r_hold;
    logic          r_sel;
    logic          r_busy;

    logic w_edge0;
    logic w_edge1;
    logic w_wrap;
    logic w_other;
    logic w_desired;
    logic w_switch;

    assign w_edge0 = r_sync0[1] ^ r_sync0[2];
    assign w_edge1 = r_sync1[1] ^ r_sync1[2];
    assign w_wrap  = (r_win == WIN_LAST);
    assign w_other = ~req_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= {r_sync0[1:0], clk0_tog};
            r_sync1 <= {r_sync1[1:0], clk1_tog};
        end
    end

    // An edge landing on the wrap cycle belongs to the new window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
            r_alive <= 2'b00;
        end else if (w_wrap) begin
            r_win   <= '0;
            r_alive <= {(r_cnt1 == TOG_SAT), (r_cnt0 == TOG_SAT)};
            r_cnt0  <= CW'(w_edge0);
            r_cnt1  <= CW'(w_edge1);
        end else begin
            r_win <= r_win + 1'b1;
            if (w_edge0 && (r_cnt0 != TOG_SAT)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_edge1 && (r_cnt1 != TOG_SAT)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    always_comb begin
        w_desired = req_sel;
        if (auto_en) begin
            if (r_alive[req_sel])      w_desired = req_sel;
            else if (r_alive[w_other]) w_desired = w_other;
            else                       w_desired = r_sel;
        end
    end

    assign w_switch = (r_state == S_ARM) && (w_desired != r_sel) && (r_hold == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_hold  <= '0;
            r_sel   <= PRESELECT;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_desired != r_sel) begin
                        r_state <= S_ARM;
                        r_hold  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (w_desired == r_sel) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end else if (w_switch) begin
                        r_sel   <= ~r_sel;
                        r_state <= S_SETTLE;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_SEL_STATUS_EN
    logic [7:0] r_switch_cnt;
    logic       r_fail_p;

    // A failover switch is one that lands on the source the user did not request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_switch_cnt <= '0;
            r_fail_p     <= 1'b0;
        end else begin
            r_fail_p <= w_switch && auto_en && (w_desired != req_sel);
            if (w_switch && (r_switch_cnt != 8'hFF)) r_switch_cnt <= r_switch_cnt + 1'b1;
        end
    end

    assign switch_cnt = r_switch_cnt;
    assign fail_p     = r_fail_p;
`endif

    assign sel         = r_sel;
    assign alive       = r_alive;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: directed steps plus randomized activity, checked against a behavioural model.
// With CLK_SEL_STATUS_EN defined the status outputs are checked as well.
module tb_clk_sel_ctrl;

    localparam int WIN_LEN   = 16;
    localparam int MIN_TOG   = 2;
    localparam int HOLD_CYC  = 4;
    localparam bit PRESELECT = 1'b0;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       clk0_tog = 1'b0;
    logic       clk1_tog = 1'b0;
    logic       req_sel  = 1'b0;
    logic       auto_en  = 1'b0;
    logic       sel;
    logic [1:0] alive;
    logic       busy;
    logic [1:0] o_dbg_state;
    logic [7:0] switch_cnt;
    logic [0:0] fail_p;

    int n_assert = 0;
    int n_fail   = 0;

    clk_sel_ctrl #(
        .WIN_LEN  (WIN_LEN),
        .MIN_TOG  (MIN_TOG),
        .HOLD_CYC (HOLD_CYC),
        .PRESELECT(PRESELECT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk0_tog   (clk0_tog),
        .clk1_tog   (clk1_tog),
        .req_sel    (req_sel),
        .auto_en    (auto_en),
        .sel        (sel),
        .alive      (alive),
        .busy       (busy),
`ifdef CLK_SEL_STATUS_EN
        .switch_cnt (switch_cnt),
        .fail_p     (fail_p),
`endif
        .o_dbg_state(o_dbg_state)
    );

`ifndef CLK_SEL_STATUS_EN
    assign switch_cnt = 8'd0;
    assign fail_p     = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    // Toggle sources: flip every perN reference cycles while enabled, away from the sampling edge
    logic en0  = 1'b1;
    logic en1  = 1'b1;
    int   per0 = 3;
    int   per1 = 3;
    int   c0   = 0;
    int   c1   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (en0) begin
                c0++;
                if (c0 >= per0) begin
                    c0 = 0;
                    clk0_tog = ~clk0_tog;
                end
            end
            if (en1) begin
                c1++;
                if (c1 >= per1) begin
                    c1 = 0;
                    clk1_tog = ~clk1_tog;
                end
            end
        end
    end

    // Reference model: edges seen three samples late, counted per window; a switch
    // happens once the mismatch has persisted HOLD_CYC+1 cycles, then HOLD_CYC quiet cycles.
    logic        h0[$];
    logic        h1[$];
    int          m_win    = 0;
    int          m_cnt0   = 0;
    int          m_cnt1   = 0;
    logic [1:0]  m_alive  = 2'b00;
    logic        m_sel    = PRESELECT;
    int          m_mism   = 0;
    int          m_settle = 0;
    int          m_swcnt  = 0;
    logic        m_failp  = 1'b0;
    logic [12:0] exp_q[$];

    always @(posedge clk) begin : model
        logic e0;
        logic e1;
        logic des;
        logic m_busy;
        logic [7:0] sw8;
        if (!rst_n) begin
            h0       = '{1'b0, 1'b0, 1'b0};
            h1       = '{1'b0, 1'b0, 1'b0};
            m_win    = 0;
            m_cnt0   = 0;
            m_cnt1   = 0;
            m_alive  = 2'b00;
            m_sel    = PRESELECT;
            m_mism   = 0;
            m_settle = 0;
            m_swcnt  = 0;
            m_failp  = 1'b0;
        end else begin
            e0 = h0[1] ^ h0[0];
            e1 = h1[1] ^ h1[0];
            h0.push_back(clk0_tog);
            h1.push_back(clk1_tog);
            void'(h0.pop_front());
            void'(h1.pop_front());
            if (!auto_en)                des = req_sel;
            else if (m_alive[req_sel])   des = req_sel;
            else if (m_alive[!req_sel])  des = !req_sel;
            else                         des = m_sel;
            if (m_win == WIN_LEN - 1) begin
                m_alive = {(m_cnt1 >= MIN_TOG), (m_cnt0 >= MIN_TOG)};
                m_cnt0  = int'(e0);
                m_cnt1  = int'(e1);
                m_win   = 0;
            end else begin
                m_cnt0 += int'(e0);
                m_cnt1 += int'(e1);
                m_win++;
            end
            m_failp = 1'b0;
            if (m_settle > 0) begin
                m_settle--;
            end else if (des != m_sel) begin
                m_mism++;
                if (m_mism == HOLD_CYC + 1) begin
                    m_failp  = auto_en && (des != req_sel);
                    m_sel    = des;
                    m_mism   = 0;
                    m_settle = HOLD_CYC;
                    if (m_swcnt < 255) m_swcnt++;
                end
            end else begin
                m_mism = 0;
            end
        end
        m_busy = (m_mism > 0) || (m_settle > 0);
        sw8    = 8'(m_swcnt);
`ifdef CLK_SEL_STATUS_EN
        exp_q.push_back({m_failp, sw8, m_busy, m_alive, m_sel});
`else
        exp_q.push_back({1'b0, 8'd0, m_busy, m_alive, m_sel});
`endif
    end

    // scoreboard
    always @(negedge clk) begin : scoreboard
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = {fail_p, switch_cnt, busy, alive, sel};
            n_assert++;
            assert (obs_v === exp_v) else begin
                n_fail++;
                $error("FAIL scoreboard t=%0t observed=%h expected=%h", $time, obs_v, exp_v);
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_alive(input string tag, input logic [1:0] target, input int budget);
        int k;
        k = 0;
        while ((alive !== target) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        assert (alive === target) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (timeout)", tag, alive, target);
        end
    endtask

    initial begin
        // reset with both sources toggling every 3 cycles
        rst_n = 1'b0;
        wait_cyc(3);
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_alive", 8'(alive), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_state", 8'(o_dbg_state), 8'd0);
        rst_n = 1'b1;
        wait_cyc(15);
        chk("alive_before_wrap", 8'(alive), 8'd0);
        wait_cyc(1);
        chk("alive_first_wrap", 8'(alive), 8'b11);

        // manual switch 0 -> 1
        auto_en = 1'b0;
        req_sel = 1'b1;
        wait_cyc(1);
        chk("man_busy_rise", 8'(busy), 8'd1);
        wait_cyc(3);
        chk("man_sel_early", 8'(sel), 8'd0);
        wait_cyc(1);
        chk("man_sel_switch", 8'(sel), 8'd1);
        wait_cyc(3);
        chk("man_busy_settle", 8'(busy), 8'd1);
        wait_cyc(1);
        chk("man_busy_fall", 8'(busy), 8'd0);

        // back to 0, then an aborted request
        req_sel = 1'b0;
        wait_cyc(12);
        chk("back_sel", 8'(sel), 8'd0);
        req_sel = 1'b1;
        wait_cyc(2);
        req_sel = 1'b0;
        wait_cyc(10);
        chk("abort_sel", 8'(sel), 8'd0);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_state", 8'(o_dbg_state), 8'd0);
        chk("abort_cnt", switch_cnt, 8'(`ifdef CLK_SEL_STATUS_EN 2 `else 0 `endif));

        // failover: clk0 dies while it is the requested source
        auto_en = 1'b1;
        req_sel = 1'b0;
        en0 = 1'b0;
        wait_alive("fo_alive_10", 2'b10, 80);
        chk("fo_busy_idle", 8'(busy), 8'd0);
        wait_cyc(1);
        chk("fo_busy_arm", 8'(busy), 8'd1);
        wait_cyc(3);
        chk("fo_sel_early", 8'(sel), 8'd0);
        wait_cyc(1);
        chk("fo_sel_switch", 8'(sel), 8'd1);
        chk("fo_fail_p", 8'(fail_p), 8'(`ifdef CLK_SEL_STATUS_EN 1 `else 0 `endif));
        wait_cyc(1);
        chk("fo_fail_p_end", 8'(fail_p), 8'd0);

        // recovery: clk0 restarts
        en0 = 1'b1;
        wait_alive("rec_alive_11", 2'b11, 80);
        wait_cyc(4);
        chk("rec_sel_early", 8'(sel), 8'd1);
        wait_cyc(1);
        chk("rec_sel_switch", 8'(sel), 8'd0);
        chk("rec_fail_p", 8'(fail_p), 8'd0);
        chk("rec_cnt", switch_cnt, 8'(`ifdef CLK_SEL_STATUS_EN 4 `else 0 `endif));

        // both dead while sel=1
        auto_en = 1'b0;
        req_sel = 1'b1;
        wait_cyc(10);
        chk("dead_pre_sel", 8'(sel), 8'd1);
        en0 = 1'b0;
        en1 = 1'b0;
        wait_alive("dead_alive_00", 2'b00, 80);
        auto_en = 1'b1;
        req_sel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            chk("dead_sel_hold", 8'(sel), 8'd1);
            chk("dead_busy", 8'(busy), 8'd0);
        end

        // reset in the middle of settle
        en0 = 1'b1;
        en1 = 1'b1;
        auto_en = 1'b0;
        wait_cyc(12);
        chk("mid_pre_sel", 8'(sel), 8'd0);
        req_sel = 1'b1;
        wait_cyc(6);
        chk("mid_sel_settle", 8'(sel), 8'd1);
        chk("mid_busy_settle", 8'(busy), 8'd1);
        rst_n = 1'b0;
        wait_cyc(1);
        chk("mid_rst_sel", 8'(sel), 8'(PRESELECT));
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_alive", 8'(alive), 8'd0);
        chk("mid_rst_cnt", switch_cnt, 8'd0);
        rst_n = 1'b1;

        // randomized activity, checked by the scoreboard every cycle
        for (int i = 0; i < 40; i++) begin
            req_sel = 1'($urandom_range(0, 1));
            auto_en = ($urandom_range(0, 3) != 0);
            en0     = ($urandom_range(0, 4) != 0);
            en1     = ($urandom_range(0, 4) != 0);
            per0    = $urandom_range(2, 8);
            per1    = $urandom_range(2, 8);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                wait_cyc(1);
                rst_n = 1'b1;
            end
            wait_cyc($urandom_range(8, 30));
        end

`ifdef CLK_SEL_STATUS_EN
        // counter saturation
        rst_n = 1'b0;
        auto_en = 1'b0;
        req_sel = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 300; i++) begin
            req_sel = ~req_sel;
            wait_cyc(9);
        end
        chk("sat_cnt", switch_cnt, 8'd255);
`endif

        wait_cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
- Clock-select controller driving the `s` input of the glitch-free BUFGMUX (directly upstream of the clock mux).
- Runs on a free-running reference clock and watches activity of both mux candidates through toggle bits generated in their own domains.
- Produces a debounced, hold-off-protected select with manual request and automatic failover.

Parameters:
- WIN_LEN, 1024: measurement window length in clk cycles (>=8).
- MIN_TOG, 4: minimum synchronized toggle edges per window for a source to be "alive" (1..WIN_LEN/4).
- HOLD_CYC, 64: arm delay before a switch, and settle time after a switch, in clk cycles (>=2).
- PRESELECT, 0: reset value of sel (0 = i0, 1 = i1).

Ports:
- clk, input, 1: free-running reference clock, independent of both monitored clocks.
- rst_n, input, 1: synchronous active-low reset.
- clk0_tog, input, 1: divide-by-2 toggle from the i0 domain, asynchronous to clk.
- clk1_tog, input, 1: divide-by-2 toggle from the i1 domain, asynchronous to clk.
- req_sel, input, 1: requested source (0/1), quasi-static.
- auto_en, input, 1: 1 enables failover when the requested source is dead.
- sel, output, 1: select to BUFGMUX `s`; registered.
- alive, output, 2: [0] = clk0 alive, [1] = clk1 alive; registered at window end.
- busy, output, 1: high in S_ARM or S_SETTLE.

Behaviour:
- Reset (rst_n=0 sampled on clk edge): sel=PRESELECT, alive=2'b00, busy=0, state=S_RUN, all counters 0, sync flops 0.
- Each tog passes a 2-FF synchronizer, then a 3rd flop for edge detect. Any change counts as 1 edge. Latency from input change to count increment is 3 clk cycles.
- Per-source edge counters, width clog2(MIN_TOG+1), saturate at MIN_TOG.
- Window counter runs 0..WIN_LEN-1 and wraps. On the wrap cycle:
  - alive[k] <= (cnt_k == MIN_TOG).
  - Both edge counters reset to 0. An edge arriving on the wrap cycle counts as 1 in the new window.
- desired:
  - auto_en=0: desired = req_sel.
  - auto_en=1: req_sel if alive[req_sel]; else ~req_sel if alive[~req_sel]; else sel (hold when both are dead).
- FSM:
  - S_RUN: if desired != sel, go to S_ARM and clear the hold counter.
  - S_ARM: hold counter increments each cycle. If desired == sel at any cycle, return to S_RUN (abort, sel unchanged). When the counter reaches HOLD_CYC-1 and desired != sel, set sel <= ~sel on that edge and go to S_SETTLE with the counter cleared.
  - S_SETTLE: ignores desired for HOLD_CYC cycles, then goes to S_RUN.
- Minimum request-to-sel latency with a stable desired: HOLD_CYC cycles after the first S_RUN mismatch cycle.
- sel changes at most once per 2*HOLD_CYC cycles.
- busy is a registered decode of state (high in S_ARM and S_SETTLE).
- Toggling req_sel during S_SETTLE: no effect until S_RUN, then re-evaluated.
- rst_n low mid-switch: immediate return to reset values on the next edge; sel returns to PRESELECT even if it was mid-S_SETTLE.

Optional Feature:
- Macro: CLK_SEL_STATUS_EN.
- Defined:
  - Adds output switch_cnt [7:0], incremented on each sel change and saturating at 255, reset to 0.
  - Adds output fail_p [0:0], a 1-cycle pulse when a switch is caused by auto failover (auto_en=1 and desired != req_sel at the switch edge).
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
Bench parameters: WIN_LEN=16, MIN_TOG=2, HOLD_CYC=4, PRESELECT=0.
- Reset: hold rst_n=0 for 3 cycles with both togs active -> sel=0, alive=00, busy=0. First alive update comes 16 cycles after release: alive=11 with both togs toggling every 3 clk.
- Manual switch: auto_en=0, req_sel 0->1 in S_RUN -> busy=1 next cycle, sel=1 exactly 4 cycles after the first mismatch cycle, busy=0 after a further 4 cycles.
- Abort: req_sel 0->1, then back to 0 after 2 cycles -> sel stays 0, state returns to S_RUN, no switch.
- Failover: auto_en=1, req_sel=0, stop clk0_tog -> after the next window wrap alive=10, sel goes 0->1 after 4 cycles. Restart clk0_tog -> alive=11 at a later window, sel returns to 0.
- Both dead: stop both togs with sel=1 -> alive=00, sel holds 1, busy stays 0.
- CLK_SEL_STATUS_EN defined, run the failover test -> fail_p pulses once, switch_cnt=2 after recovery. Force 300 manual switches -> switch_cnt=255.
